// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
// Shared definitions for the modulo counter slice: the FSM state encoding and
// the default parameter values used by mod_counter and its prescaler.
// -----------------------------------------------------------------------------
package mod_counter_pkg;

    localparam int DEF_WIDTH   = 10;
    localparam int DEF_MODULUS = 1000;
    localparam int DEF_PRESC_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_presc.sv
// -----------------------------------------------------------------------------
// mod_counter_presc
// Prescaler for mod_counter. It counts enabled cycles and raises tick on every
// (div+1)-th enabled cycle. When en is low, the phase is frozen.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous, active-low reset; clears the phase
//   en   in   advance the phase this cycle
//   div  in   divide field; tick every div+1 enabled cycles
//   tick out  combinational, high on the enabled cycle that completes a period
// -----------------------------------------------------------------------------
module mod_counter_presc
    import mod_counter_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] phase_q;
    logic [PRESC_W-1:0] phase_d;

    // ">=" instead of "==" guards against div shrinking below the current phase,
    // which would otherwise cause a long wrap-around before the next tick.
    always_comb begin
        tick    = en && (phase_q >= div);
        phase_d = phase_q;
        if (en) begin
            phase_d = tick ? '0 : phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule : mod_counter_presc

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Up/down modulo-MODULUS counter with start/stop/load control, a one-shot mode
// and an optional prescaler.
// Configuration macro: PRESCALE_EN. When it is defined, the counter steps every
// presc_div+1 enabled RUN cycles. When it is undefined, the counter steps on
// every enabled RUN cycle, and presc_div is ignored.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-low reset
//   start      in   pulse: IDLE/DONE -> RUN
//   stop       in   pulse: -> IDLE, count held
//   en         in   count enable while in RUN
//   up_dn      in   1 = up, 0 = down
//   oneshot    in   1 = stop in DONE on terminal step, 0 = wrap and continue
//   load       in   load load_val (clamped to MODULUS-1) into the count
//   load_val   in   value to load
//   presc_div  in   prescaler divide field
//   cnt        out  registered count, always in 0..MODULUS-1
//   tc         out  one-cycle pulse when cnt first shows the post-terminal value
//   done       out  high in DONE
//   busy       out  high in RUN
// Per-cycle priority: rst > stop > load > start > count step.
// -----------------------------------------------------------------------------
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               en,
    input  logic               up_dn,
    input  logic               oneshot,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [PRESC_W-1:0] presc_div,
    output logic [WIDTH-1:0]   cnt,
    output logic               tc,
    output logic               done,
    output logic               busy
);

    // Both constants are WIDTH+1 bits, so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    logic             presc_en;
    logic             tick;
    logic             step;
    logic             term;
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   nxt_x;

    // Saturate a WIDTH+1-bit candidate into the legal range 0..MODULUS-1.
    function automatic logic [WIDTH-1:0] fit(input logic [WIDTH:0] v);
        if (v >= MOD_X) begin
            return MAX_X[WIDTH-1:0];
        end
        return v[WIDTH-1:0];
    endfunction

    // The prescaler advances only on cycles that could actually step.
    // Otherwise a higher-priority stop or load would silently consume a tick.
    assign presc_en = (state_q == RUN) && en && !stop && !load;

`ifdef PRESCALE_EN
    mod_counter_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .div  (presc_div),
        .tick (tick)
    );
`else
    logic unused_presc;
    assign unused_presc = ^presc_div;
    assign tick         = presc_en;
`endif

    assign step = presc_en && tick;

    always_comb begin
        cnt_x = {1'b0, cnt_q};
        if (up_dn) begin
            term  = (cnt_x == MAX_X);
            nxt_x = term ? '0 : cnt_x + 1'b1;
        end else begin
            term  = (cnt_x == '0);
            nxt_x = term ? MAX_X : cnt_x - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else if (load) begin
            cnt_d = fit({1'b0, load_val});
        end else if (start && (state_q != RUN)) begin
            state_d = RUN;
        end else if (step) begin
            cnt_d = fit(nxt_x);
            if (term) begin
                tc_d = 1'b1;
                if (oneshot) begin
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc   = tc_q;
    assign done = (state_q == DONE);
    assign busy = (state_q == RUN);

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
// Directed bench for mod_counter with WIDTH=10 and MODULUS=10. Stimulus pushes
// the state expected after each clock edge. A monitor pops the expected state
// on the following falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mod_counter;

    localparam int WIDTH   = 10;
    localparam int MODULUS = 10;
    localparam int PRESC_W = 4;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] cnt;
        logic             tc;
        logic             done;
        logic             busy;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               en;
    logic               up_dn;
    logic               oneshot;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic [PRESC_W-1:0] presc_div;
    logic [WIDTH-1:0]   cnt;
    logic               tc;
    logic               done;
    logic               busy;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mod_counter #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .up_dn     (up_dn),
        .oneshot   (oneshot),
        .load      (load),
        .load_val  (load_val),
        .presc_div (presc_div),
        .cnt       (cnt),
        .tc        (tc),
        .done      (done),
        .busy      (busy)
    );

    // The monitor compares the DUT outputs with the state expected after the
    // most recent rising edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e  = exp_q.pop_front();
            checks = checks + 1;
            if (cnt !== mon_e.cnt || tc !== mon_e.tc || done !== mon_e.done || busy !== mon_e.busy) begin
                errors = errors + 1;
                $display("FAIL %s: got cnt=%0d tc=%b done=%b busy=%b, want cnt=%0d tc=%b done=%b busy=%b",
                         mon_e.name, cnt, tc, done, busy, mon_e.cnt, mon_e.tc, mon_e.done, mon_e.busy);
            end
        end
    end

    // Apply the current inputs for one clock edge, then queue the state that
    // the outputs must show after that edge.
    task automatic cyc(input string nm, input int c, input bit t, input bit d, input bit b);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = nm;
        e.cnt  = c[WIDTH-1:0];
        e.tc   = t;
        e.done = d;
        e.busy = b;
        exp_q.push_back(e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; up_dn = 1'b1;
        oneshot = 1'b0; load = 1'b0; load_val = '0; presc_div = '0;

        // Reset state: start is held high to show that reset overrides it.
        start = 1'b1;
        cyc("reset0", 0, 0, 0, 0);
        cyc("reset1", 0, 0, 0, 0);
        start = 1'b0;
        rst = 1'b1;

        // Up count 0..9 then wrap to 0, with tc high on the wrap cycle.
        en = 1'b1; up_dn = 1'b1; start = 1'b1;
        cyc("up_start", 0, 0, 0, 1);
        start = 1'b0;
        for (int i = 1; i <= 10; i++) cyc("up", i % 10, (i == 10), 0, 1);
        cyc("up_after_wrap", 1, 0, 0, 1);

        // Down count from a loaded 2: 2,1,0,9(tc),8.
        stop = 1'b1;
        cyc("stop", 1, 0, 0, 0);
        stop = 1'b0;
        load_val = 10'd2; load = 1'b1;
        cyc("load2", 2, 0, 0, 0);
        load = 1'b0; up_dn = 1'b0; start = 1'b1;
        cyc("dn_start", 2, 0, 0, 1);
        start = 1'b0;
        cyc("dn1", 1, 0, 0, 1);
        cyc("dn0", 0, 0, 0, 1);
        cyc("dn_wrap9", 9, 1, 0, 1);
        cyc("dn8", 8, 0, 0, 1);

        // One-shot from 7: load in RUN keeps RUN, then 8,9,0 -> DONE, then hold.
        load_val = 10'd7; load = 1'b1; up_dn = 1'b1; oneshot = 1'b1;
        cyc("load7_run", 7, 0, 0, 1);
        load = 1'b0;
        cyc("os8", 8, 0, 0, 1);
        cyc("os9", 9, 0, 0, 1);
        cyc("os_term", 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) cyc("os_hold", 0, 0, 1, 0);

        // Load clamp in DONE, restart, then load+stop together in RUN.
        load_val = 10'd15; load = 1'b1;
        cyc("clamp15", 9, 0, 1, 0);
        load = 1'b0; oneshot = 1'b0; start = 1'b1;
        cyc("restart", 9, 0, 0, 1);
        start = 1'b0;
        cyc("wrap_after_clamp", 0, 1, 0, 1);
        cyc("run1", 1, 0, 0, 1);
        load_val = 10'd5; load = 1'b1; stop = 1'b1;
        cyc("load_stop", 1, 0, 0, 0);
        load = 1'b0; stop = 1'b0;
        cyc("idle_hold", 1, 0, 0, 0);

        // Simultaneous start and stop: stop wins.
        start = 1'b1; stop = 1'b1;
        cyc("start_stop", 1, 0, 0, 0);
        stop = 1'b0;

        // Direction change mid-run, then en=0 freeze.
        cyc("dir_start", 1, 0, 0, 1);
        start = 1'b0;
        cyc("dir_up2", 2, 0, 0, 1);
        up_dn = 1'b0;
        cyc("dir_dn1", 1, 0, 0, 1);
        up_dn = 1'b1;
        cyc("dir_up2b", 2, 0, 0, 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) cyc("en_freeze", 2, 0, 0, 1);
        en = 1'b1;
        for (int i = 3; i <= 6; i++) cyc("to6", i, 0, 0, 1);

        // Reset mid-run at cnt=6.
        rst = 1'b0;
        cyc("rst_mid", 0, 0, 0, 0);
        rst = 1'b1;
        cyc("post_rst_idle", 0, 0, 0, 0);

`ifdef PRESCALE_EN
        // Prescaler /4 with an en=0 gap mid-period, then reset discarding phase.
        presc_div = 4'd3; start = 1'b1;
        cyc("ps_start", 0, 0, 0, 1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ps_wait0", 0, 0, 0, 1);
        cyc("ps_step1", 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc("ps_wait1", 1, 0, 0, 1);
        cyc("ps_step2", 2, 0, 0, 1);
        cyc("ps_ph1", 2, 0, 0, 1);
        cyc("ps_ph2", 2, 0, 0, 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) cyc("ps_gap", 2, 0, 0, 1);
        en = 1'b1;
        cyc("ps_ph3", 2, 0, 0, 1);
        cyc("ps_step3", 3, 0, 0, 1);
        cyc("ps_ph1b", 3, 0, 0, 1);
        cyc("ps_ph2b", 3, 0, 0, 1);
        rst = 1'b0;
        cyc("ps_rst", 0, 0, 0, 0);
        rst = 1'b1; start = 1'b1;
        cyc("ps_restart", 0, 0, 0, 1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ps_full_wait", 0, 0, 0, 1);
        cyc("ps_first_step", 1, 0, 0, 1);
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mod_counter

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 10: count register width in bits.
REQ-002 SHALL have parameter MODULUS, default 1000: count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have parameter PRESC_W, default 4: prescaler divide-field width.
REQ-004 Ports: clk  input  1  clock; all logic on rising edge.
REQ-005 Ports: rst  input  1  synchronous, active-low reset.
REQ-006 Ports: start  input  1  pulse; leave IDLE/DONE and enter RUN.
REQ-007 Ports: stop  input  1  pulse; return to IDLE and hold the count.
REQ-008 Ports: en  input  1  count-enable qualifier while in RUN.
REQ-009 Ports: up_dn  input  1  1 = count up, 0 = count down.
REQ-010 Ports: oneshot  input  1  1 = halt in DONE at terminal count, 0 = wrap and continue.
REQ-011 Ports: load  input  1  load load_val into the count.
REQ-012 Ports: load_val  input  WIDTH  value to load.
REQ-013 Ports: presc_div  input  PRESC_W  step every presc_div+1 enabled cycles.
REQ-014 Ports: cnt  output  WIDTH  registered count.
REQ-015 Ports: tc  output  1  one-cycle terminal-count pulse.
REQ-016 Ports: done  output  1  high while in DONE.
REQ-017 Ports: busy  output  1  high while in RUN.

Function
REQ-018 FSM SHALL have states IDLE, RUN and DONE.
REQ-019 Transitions: IDLE/DONE -> RUN on start; RUN -> IDLE on stop; RUN -> DONE on a terminal step when oneshot=1.
REQ-020 Per-cycle priority SHALL be rst > stop > load > start > count step.
REQ-021 load SHALL set cnt to load_val in any state without changing state; values >= MODULUS clamp to MODULUS-1.
REQ-022 A step SHALL occur only in RUN, with en=1, on a prescaler tick.
REQ-023 Up step: cnt+1; from MODULUS-1 the step wraps to 0 and is a terminal step.
REQ-024 Down step: cnt-1; from 0 the step wraps to MODULUS-1 and is a terminal step.
REQ-025 In oneshot mode, a terminal step SHALL load the wrapped value and enter DONE.
REQ-026 tc SHALL be high for exactly the one cycle in which cnt first shows the post-terminal-step value.
REQ-027 up_dn changes SHALL take effect on the next step; no glitch or skipped value.
REQ-028 en=0 SHALL freeze both cnt and the prescaler phase.
REQ-029 Arithmetic SHALL use WIDTH+1 bits internally; no out-of-range value SHALL ever appear on cnt.
REQ-030 Simultaneous start and stop: stop wins; the next state is IDLE.

Reset
REQ-031 rst=0 at a clk edge SHALL force IDLE, cnt=0, tc=0, done=0, busy=0 and clear the prescaler phase, overriding all other inputs.
REQ-032 Reset mid-RUN SHALL discard any pending step; the first step after restart needs a full presc_div+1 enabled cycles.

Configuration
REQ-033 Macro PRESCALE_EN defined: prescaler active as in REQ-013.
REQ-034 Macro PRESCALE_EN undefined: every enabled RUN cycle is a tick; presc_div remains a port but is ignored; no prescaler flops are built.

Structure
REQ-035 Package mod_counter_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default parameter constants.
REQ-036 The prescaler SHALL be a sub-module, mod_counter_presc (inputs clk, rst, en, div; output tick), instantiated only under PRESCALE_EN.

Verification (WIDTH=10, MODULUS=10)
REQ-037 Up count: reset, start, en=1, up, presc_div=0 -> cnt 0,1,...,9,0; tc high only on the 0 cycle; busy stays 1.
REQ-038 Down count: load_val=2, load, start, up_dn=0 -> cnt 2,1,0,9,8; tc high on the 9 cycle.
REQ-039 Oneshot: oneshot=1, up from 7 -> 8,9,0; then DONE with done=1, busy=0; cnt holds 0 for 20 cycles.
REQ-040 Load clamp and priority: load_val=15 with load=1 -> cnt=9; load+stop together in RUN -> IDLE, cnt unchanged.
REQ-041 Prescaler (PRESCALE_EN): presc_div=3 -> one step every 4 cycles; en=0 for 5 cycles mid-period -> phase resumes without loss.
REQ-042 Reset mid-run: rst=0 at cnt=6 -> next cycle cnt=0, IDLE, tc=0, done=0.
